// File: rtl/ls_addr_gen.sv
// Load/store address generator: log barrel shifter feeding a 32-bit carry-lookahead
// adder/subtractor, with the memory and writeback addresses registered (1-cycle latency).
module ls_addr_gen (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  input  logic        I,
  input  logic        P,
  input  logic        U,
  input  logic [1:0]  SH_OP,
  input  logic [4:0]  SH_AMOUNT,
  input  logic [11:0] OFFSET,
  input  logic [31:0] RN,
  input  logic [31:0] RM,
  output logic        OUT_VALID,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] WB_ADDR,
  output logic        COUT
);

  // Valid semantics: OUT_VALID is IN_VALID delayed one cycle and only qualifies the
  // address outputs, which update every cycle; there is no ready/back-pressure.

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;

  function automatic logic [31:0] shift_stage(input logic [31:0] d,
                                              input logic [1:0]  op,
                                              input int          n);
    logic [31:0] r;
    case (op)
      SH_LSL:  r = d << n;
      SH_LSR:  r = d >> n;
      SH_ASR:  r = (d >> n) | (~(32'hFFFF_FFFF >> n) & {32{d[31]}});
      default: r = (d >> n) | (d << (32 - n));
    endcase
    return r;
  endfunction

  logic [31:0] sh_out;
  logic [31:0] offset_val;
  logic [31:0] b_op;
  logic        cin;
  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] bit_c;
  logic [3:0]  gb;
  logic [3:0]  pb;
  logic        grp_g;
  logic        grp_p;
  logic        run_c;
  logic        carry_out;
  logic [31:0] sum;

  // Five stages of 1, 2, 4, 8 and 16 positions, each enabled by one SH_AMOUNT bit.
  always_comb begin
    sh_out = RM;
    for (int k = 0; k < 5; k++) begin
      if (SH_AMOUNT[k]) sh_out = shift_stage(sh_out, SH_OP, 1 << k);
    end
  end

  assign offset_val = I ? sh_out : {20'b0, OFFSET};
  assign b_op       = U ? offset_val : ~offset_val;
  assign cin        = ~U;
  assign g          = RN & b_op;
  assign p          = RN ^ b_op;

  // 4-bit lookahead groups; group generate/propagate form the carry chain between groups.
  always_comb begin
    run_c = cin;
    bit_c = '0;
    gb    = '0;
    pb    = '0;
    grp_g = 1'b0;
    grp_p = 1'b0;
    for (int j = 0; j < 8; j++) begin
      gb = g[4*j +: 4];
      pb = p[4*j +: 4];
      bit_c[4*j]   = run_c;
      bit_c[4*j+1] = gb[0] | (pb[0] & run_c);
      bit_c[4*j+2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & run_c);
      bit_c[4*j+3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                   | (pb[2] & pb[1] & pb[0] & run_c);
      grp_g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
            | (pb[3] & pb[2] & pb[1] & gb[0]);
      grp_p = &pb;
      run_c = grp_g | (grp_p & run_c);
    end
    carry_out = run_c;
  end

  assign sum = p ^ bit_c;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OUT_VALID <= 1'b0;
      MEM_ADDR  <= '0;
      WB_ADDR   <= '0;
      COUT      <= 1'b0;
    end else begin
      OUT_VALID <= IN_VALID;
      MEM_ADDR  <= P ? sum : RN;
      WB_ADDR   <= sum;
      COUT      <= carry_out;
    end
  end

endmodule

// File: tb/tb_ls_addr_gen.sv
// Self-checking bench for ls_addr_gen: directed cases with literal expectations plus
// randomized vectors checked against a behavioural shift/add/subtract model.
module tb_ls_addr_gen;

  localparam int W = 66;  // {valid, mem_addr, wb_addr, cout}

  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic        I;
  logic        P;
  logic        U;
  logic [1:0]  SH_OP;
  logic [4:0]  SH_AMOUNT;
  logic [11:0] OFFSET;
  logic [31:0] RN;
  logic [31:0] RM;
  logic        OUT_VALID;
  logic [31:0] MEM_ADDR;
  logic [31:0] WB_ADDR;
  logic        COUT;

  logic [W-1:0] exp_q[$];
  int checks_total;
  int checks_passed;

  typedef struct packed {
    logic        i;
    logic        p;
    logic        u;
    logic [1:0]  op;
    logic [4:0]  amt;
    logic [11:0] off;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] mem;
    logic [31:0] wb;
    logic        c;
  } dvec_t;

  ls_addr_gen dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .I         (I),
    .P         (P),
    .U         (U),
    .SH_OP     (SH_OP),
    .SH_AMOUNT (SH_AMOUNT),
    .OFFSET    (OFFSET),
    .RN        (RN),
    .RM        (RM),
    .OUT_VALID (OUT_VALID),
    .MEM_ADDR  (MEM_ADDR),
    .WB_ADDR   (WB_ADDR),
    .COUT      (COUT)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural reference: shift as plain operators, add/subtract in 33-bit arithmetic.
  function automatic logic [W-1:0] model(input logic v, input logic i, input logic p,
                                         input logic u, input logic [1:0] op,
                                         input logic [4:0] amt, input logic [11:0] off,
                                         input logic [31:0] rn, input logic [31:0] rm);
    logic signed [31:0] srm;
    logic [63:0] rr;
    logic [31:0] sh;
    logic [31:0] o;
    logic [32:0] full;
    logic [31:0] s;
    logic        c;
    srm = rm;
    rr  = {rm, rm} >> amt;
    case (op)
      2'd0:    sh = rm << amt;
      2'd1:    sh = rm >> amt;
      2'd2:    sh = srm >>> amt;
      default: sh = rr[31:0];
    endcase
    o = i ? sh : {20'b0, off};
    if (u) begin
      full = {1'b0, rn} + {1'b0, o};
      s = full[31:0];
      c = full[32];
    end else begin
      s = rn - o;
      c = (rn >= o);
    end
    return {v, (p ? s : rn), s, c};
  endfunction

  // Driver
  task automatic drive(input logic v, input logic i, input logic p, input logic u,
                       input logic [1:0] op, input logic [4:0] amt, input logic [11:0] off,
                       input logic [31:0] rn, input logic [31:0] rm);
    IN_VALID  = v;
    I         = i;
    P         = p;
    U         = u;
    SH_OP     = op;
    SH_AMOUNT = amt;
    OFFSET    = off;
    RN        = rn;
    RM        = rm;
  endtask

  task automatic drive_random();
    logic [4:0] amt;
    amt = 5'($urandom_range(0, 31));
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), amt,
          12'($urandom_range(0, 4095)), $urandom, $urandom);
  endtask

  task automatic test_reset();
    logic [W-1:0] got;
    RST = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 5'd0, 12'h004, 32'h100, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    got = {OUT_VALID, MEM_ADDR, WB_ADDR, COUT};
    checks_total++;
    if (got !== '0) $display("FAIL reset_state got=%h exp=%h", got, {W{1'b0}});
    else checks_passed++;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_directed();
    dvec_t tbl [9];
    logic [W-1:0] got;
    logic [W-1:0] exp;
    tbl[0] = '{1'b0, 1'b1, 1'b1, 2'd0, 5'd0, 12'h004, 32'h0000_0100, 32'h0,
               32'h0000_0104, 32'h0000_0104, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 2'd0, 5'd2, 12'h000, 32'h0000_0100, 32'h3,
               32'h0000_00F4, 32'h0000_00F4, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 2'd2, 5'd4, 12'h000, 32'h0000_0010, 32'h8000_0000,
               32'hF800_0010, 32'hF800_0010, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 2'd1, 5'd4, 12'h000, 32'h0000_0010, 32'h8000_0000,
               32'h0800_0010, 32'h0800_0010, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 2'd3, 5'd1, 12'h000, 32'h0000_0010, 32'h1,
               32'h8000_0010, 32'h8000_0010, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 12'h001, 32'h0000_0000, 32'h0,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 2'd0, 5'd0, 12'h001, 32'hFFFF_FFFF, 32'h0,
               32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 2'd0, 5'd0, 12'h010, 32'h0000_0200, 32'h0,
               32'h0000_0200, 32'h0000_0210, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 2'd3, 5'd0, 12'h000, 32'h0000_0001, 32'h1234_5678,
               32'h1234_5679, 32'h1234_5679, 1'b0};
    for (int n = 0; n < 9; n++) begin
      drive(1'b1, tbl[n].i, tbl[n].p, tbl[n].u, tbl[n].op, tbl[n].amt, tbl[n].off,
            tbl[n].rn, tbl[n].rm);
      @(posedge CLK);
      #1;
      got = {OUT_VALID, MEM_ADDR, WB_ADDR, COUT};
      exp = {1'b1, tbl[n].mem, tbl[n].wb, tbl[n].c};
      checks_total++;
      if (got !== exp) $display("FAIL directed_%0d got=%h exp=%h", n, got, exp);
      else checks_passed++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    int errs;
    errs = 0;
    for (int n = 0; n < 10000; n++) begin
      drive_random();
      if (n % 8 == 0) SH_AMOUNT = 5'd0;
      if (n % 8 == 1) SH_AMOUNT = 5'd31;
      exp_q.push_back(model(IN_VALID, I, P, U, SH_OP, SH_AMOUNT, OFFSET, RN, RM));
      @(posedge CLK);
      #1;
      got = {OUT_VALID, MEM_ADDR, WB_ADDR, COUT};
      exp = exp_q.pop_front();
      checks_total++;
      if (got !== exp) begin
        errs++;
        if (errs <= 10) $display("FAIL random_%0d got=%h exp=%h", n, got, exp);
      end else begin
        checks_passed++;
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    for (int n = 0; n < 4; n++) begin
      drive_random();
      exp_q.push_back(model(IN_VALID, I, P, U, SH_OP, SH_AMOUNT, OFFSET, RN, RM));
      @(posedge CLK);
      #1;
      got = {OUT_VALID, MEM_ADDR, WB_ADDR, COUT};
      exp = exp_q.pop_front();
      checks_total++;
      if (got !== exp) $display("FAIL b2b_%0d got=%h exp=%h", n, got, exp);
      else checks_passed++;
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 5'd0, 12'hFFF, 32'hFFFF_0000, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    exp_q.delete();
    got = {OUT_VALID, MEM_ADDR, WB_ADDR, COUT};
    checks_total++;
    if (got !== '0) $display("FAIL async_reset got=%h exp=%h", got, {W{1'b0}});
    else checks_passed++;
    @(posedge CLK);
    #1;
    got = {OUT_VALID, MEM_ADDR, WB_ADDR, COUT};
    checks_total++;
    if (got !== '0) $display("FAIL reset_hold got=%h exp=%h", got, {W{1'b0}});
    else checks_passed++;
    @(negedge CLK);
    RST = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 5'd0, 12'h020, 32'h0000_1000, 32'h0);
    exp_q.push_back(model(IN_VALID, I, P, U, SH_OP, SH_AMOUNT, OFFSET, RN, RM));
    @(posedge CLK);
    #1;
    got = {OUT_VALID, MEM_ADDR, WB_ADDR, COUT};
    exp = exp_q.pop_front();
    checks_total++;
    if (got !== exp) $display("FAIL post_reset_first got=%h exp=%h", got, exp);
    else checks_passed++;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back_reset();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
